board_ctrl: RTL and testbench

- Owns the 9x9 Sudoku board state and game stage that drive the VGA pixel generator (`stage`, `board`, `board_blank`).
- Sequences puzzle loading from a streaming source and arbitrates board writes between the loader, the handwriting/keypad entry path and a clear command.
- Sits between input/recognition logic and the VGA pixel generator.

---
 rtl/board_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_board_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// Sudoku board/stage owner for the VGA path: sequences puzzle loading,
// arbitrates loader, user-entry and clear writes, and flags a full board.
module board_ctrl #(
  parameter int unsigned CELLS = 81,
  parameter int unsigned CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  quit,
  input  logic                  clr,
  input  logic                  ld_valid,
  input  logic [CW-1:0]         ld_data,
  output logic                  ld_ready,
  input  logic                  usr_valid,
  input  logic [3:0]            usr_row,
  input  logic [3:0]            usr_col,
  input  logic [CW-1:0]         usr_data,
  output logic                  usr_ready,
  output logic                  usr_ack,
  output logic                  usr_rej,
  output logic                  stage,
  output logic [CELLS*CW-1:0]   board,
  output logic [CELLS-1:0]      board_blank,
  output logic                  board_full,
  output logic                  busy
);

  localparam int unsigned IW   = 7;
  localparam int unsigned NDIM = 9;
  localparam int unsigned DMAX = 9;
  localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_LOAD  = 2'd1,
    S_PLAY  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_board [CELLS];
  logic [CELLS-1:0] r_blank;
  logic             r_stage;
  logic             r_busy;
  logic             r_full;
  logic             r_usr_ack;
  logic             r_usr_rej;

  logic             w_ld_fire;
  logic             w_usr_fire;
  logic             w_clr_step;
  logic [CW-1:0]    w_ld_digit;
  logic [IW-1:0]    w_usr_cell;
  logic             w_usr_in_range;
  logic             w_cell_editable;
  logic             w_usr_ok;
  logic             w_all_nz;

  // Loader digits outside 1..9 are stored as empty cells.
  assign w_ld_digit = (ld_data > CW'(DMAX)) ? '0 : ld_data;

  // Row/column/digit range check, then editability of the addressed cell.
  assign w_usr_cell      = IW'(usr_row) * IW'(NDIM) + IW'(usr_col);
  assign w_usr_in_range  = (usr_row < 4'(NDIM)) && (usr_col < 4'(NDIM)) &&
                           (usr_data <= CW'(DMAX));
  assign w_cell_editable = (w_usr_cell < IW'(CELLS)) ? r_blank[w_usr_cell] : 1'b0;
  assign w_usr_ok        = w_usr_in_range && w_cell_editable;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_MENU;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; quit dominates every non-menu state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_MENU: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (quit)                                   w_state_nxt = S_MENU;
        else if (w_ld_fire && (r_idx == LAST_IDX))  w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (quit)     w_state_nxt = S_MENU;
        else if (clr) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (quit)                       w_state_nxt = S_MENU;
        else if (r_idx == LAST_IDX)     w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_MENU;
    endcase
  end

  // FSM outputs: handshake readies and per-cycle write strobes.
  always_comb begin
    ld_ready   = 1'b0;
    usr_ready  = 1'b0;
    w_clr_step = 1'b0;
    case (r_state)
      S_LOAD:  ld_ready   = ~quit;
      S_PLAY:  usr_ready  = ~clr & ~quit;
      S_CLEAR: w_clr_step = ~quit;
      default: ;
    endcase
    w_ld_fire  = ld_valid & ld_ready;
    w_usr_fire = usr_valid & usr_ready;
  end

  // Walk index restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_state_nxt != r_state) begin
      r_idx <= '0;
    end else if (w_ld_fire || w_clr_step) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  // Board storage; the three writers are exclusive by state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CELLS); i++) begin
        r_board[i] <= '0;
      end
      r_blank <= '1;
    end else begin
      if (w_ld_fire) begin
        r_board[r_idx] <= w_ld_digit;
        r_blank[r_idx] <= (w_ld_digit == '0);
      end
      if (w_usr_fire && w_usr_ok) begin
        r_board[w_usr_cell] <= usr_data;
      end
      if (w_clr_step && r_blank[r_idx]) begin
        r_board[r_idx] <= '0;
      end
    end
  end

  // Registered status and response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage   <= 1'b0;
      r_busy    <= 1'b0;
      r_full    <= 1'b0;
      r_usr_ack <= 1'b0;
      r_usr_rej <= 1'b0;
    end else begin
      r_stage   <= (w_state_nxt != S_MENU);
      r_busy    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_CLEAR);
      r_full    <= w_all_nz;
      r_usr_ack <= w_usr_fire &  w_usr_ok;
      r_usr_rej <= w_usr_fire & ~w_usr_ok;
    end
  end

  always_comb begin
    w_all_nz = 1'b1;
    for (int i = 0; i < int'(CELLS); i++) begin
      if (r_board[i] == '0) w_all_nz = 1'b0;
    end
  end

  always_comb begin
    board = '0;
    for (int i = 0; i < int'(CELLS); i++) begin
      board[i*CW +: CW] = r_board[i];
    end
  end

  assign board_blank = r_blank;
  assign board_full  = r_full;
  assign busy        = r_busy;
  assign stage       = r_stage;
  assign usr_ack     = r_usr_ack;
  assign usr_rej     = r_usr_rej;

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: user-write responses are queued at drive
// time and retired by a monitor; board contents are compared to a model.
module tb_board_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, start, quit, clr, ld_valid, usr_valid;
  logic [3:0]   ld_data, usr_row, usr_col, usr_data;
  logic         ld_ready, usr_ready, usr_ack, usr_rej, stage, board_full, busy;
  logic [323:0] board;
  logic [80:0]  board_blank;

  int           n_total = 0;
  int           n_bad   = 0;
  bit           exp_q[$];
  logic [3:0]   m_board [81];
  logic [80:0]  m_blank;

  board_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .quit(quit), .clr(clr),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .usr_valid(usr_valid), .usr_row(usr_row), .usr_col(usr_col),
    .usr_data(usr_data), .usr_ready(usr_ready), .usr_ack(usr_ack),
    .usr_rej(usr_rej), .stage(stage), .board(board),
    .board_blank(board_blank), .board_full(board_full), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [323:0] got, input logic [323:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [323:0] m_pack();
    logic [323:0] v;
    v = '0;
    for (int i = 0; i < 81; i++) v[i*4 +: 4] = m_board[i];
    return v;
  endfunction

  function automatic int pattern(input int sel, input int i);
    case (sel)
      0:       return (i == 0) ? 0 : (i == 40) ? 12 : (i % 9) + 1;
      1:       return (i * 7) % 10;
      default: return (i * 4) % 11;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 81; i++) m_board[i] = 4'd0;
    m_blank = '1;
  endtask

  // Retire one queued expectation per response pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (usr_ack && usr_rej) begin
        chk("ack_rej_both", {usr_ack, usr_rej}, 2'b00);
      end else if (usr_ack || usr_rej) begin
        if (exp_q.size() == 0) chk("usr_unexpected", {usr_ack, usr_rej}, 2'b00);
        else                   chk("usr_resp_ack", usr_ack, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load_cells(input int n, input int sel, input int stall_at);
    int d;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        @(negedge clk); ld_valid = 1'b0;
      end
      d = pattern(sel, i);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 4'(d);
      if (d > 9) d = 0;
      m_board[i] = 4'(d);
      m_blank[i] = (d == 0);
    end
  endtask

  task automatic usr_write(input int r, input int c, input int d);
    bit ok;
    @(negedge clk);
    usr_valid = 1'b1;
    usr_row   = 4'(r);
    usr_col   = 4'(c);
    usr_data  = 4'(d);
    ok = (r <= 8) && (c <= 8) && (d <= 9);
    if (ok) ok = m_blank[r*9 + c];
    exp_q.push_back(ok);
    if (ok) m_board[r*9 + c] = 4'(d);
  endtask

  task automatic usr_idle();
    @(negedge clk); usr_valid = 1'b0;
    @(negedge clk);
    chk("resp_pending", exp_q.size(), 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; quit = 1'b0; clr = 1'b0;
    ld_valid = 1'b0; ld_data = 4'd0;
    usr_valid = 1'b0; usr_row = 4'd0; usr_col = 4'd0; usr_data = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_stage", stage, 0);
    chk("rst_board", board, m_pack());
    chk("rst_blank", board_blank, m_blank);
    chk("rst_full_busy", {board_full, busy}, 2'b00);
    chk("rst_ack_rej", {usr_ack, usr_rej}, 2'b00);
    chk("rst_readies", {ld_ready, usr_ready}, 2'b00);
    rst_n = 1'b1;

    // Menu ignores loader data
    @(negedge clk); ld_valid = 1'b1; ld_data = 4'd3;
    #1 chk("menu_ld_ready", ld_ready, 0);
    @(negedge clk); ld_valid = 1'b0;

    pulse_start();
    chk("load_stage", stage, 1);
    chk("load_busy", busy, 1);
    chk("load_ld_ready", ld_ready, 1);
    load_cells(81, 0, 20);
    @(negedge clk); ld_valid = 1'b0;
    chk("play_stage", stage, 1);
    chk("play_busy", busy, 0);
    chk("load_blank", board_blank, (81'd1 << 40) | 81'd1);
    chk("load_board", board, m_pack());
    #1 chk("play_usr_ready", usr_ready, 1);
    chk("play_ld_ready", ld_ready, 0);
    @(negedge clk);
    chk("load_full", board_full, 0);

    // Accepted writes and full-flag lag
    usr_write(0, 0, 5);
    usr_idle();
    chk("w00_digit", board[3:0], 4'd5);
    usr_write(4, 4, 7);
    @(negedge clk); usr_valid = 1'b0;
    chk("full_lag", board_full, 0);
    @(negedge clk);
    chk("full_set", board_full, 1);
    chk("resp_pending", exp_q.size(), 0);

    // Back-to-back refusals
    usr_write(0, 1, 3);
    usr_write(9, 0, 3);
    usr_write(0, 0, 12);
    usr_write(0, 9, 1);
    usr_idle();
    chk("rej_board", board, m_pack());
    chk("rej_full", board_full, 1);

    // Back-to-back accepts, including an erase
    usr_write(0, 0, 9);
    usr_write(4, 4, 0);
    usr_idle();
    chk("b2b_board", board, m_pack());
    chk("erase_full", board_full, 0);

    // Clear wins over a same-cycle user write; clr during clear ignored
    @(negedge clk);
    clr = 1'b1; usr_valid = 1'b1; usr_row = 4'd0; usr_col = 4'd0; usr_data = 4'd3;
    #1 chk("clr_usr_ready", usr_ready, 0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
      clr = (c == 10);
      if (c == 5) begin
        #1 chk("clear_usr_ready", usr_ready, 0);
      end
      cnt++;
    end
    clr = 1'b0; usr_valid = 1'b0;
    for (int i = 0; i < 81; i++) if (m_blank[i]) m_board[i] = 4'd0;
    chk("clear_cycles", cnt, 81);
    chk("clear_board", board, m_pack());
    chk("clear_blank", board_blank, m_blank);
    @(negedge clk);
    chk("clear_full", board_full, 0);

    // Quit from play retains the board
    @(negedge clk); quit = 1'b1;
    @(negedge clk); quit = 1'b0;
    chk("quit_stage", stage, 0);
    chk("quit_board", board, m_pack());
    @(negedge clk); clr = 1'b1; usr_valid = 1'b1; usr_data = 4'd4;
    #1 chk("menu_usr_ready", usr_ready, 0);
    @(negedge clk); clr = 1'b0; usr_valid = 1'b0;
    chk("menu_stays", {stage, busy}, 2'b00);

    // Quit mid-load drops the same-cycle transfer
    pulse_start();
    load_cells(30, 1, -1);
    @(negedge clk); quit = 1'b1; ld_valid = 1'b1; ld_data = 4'd6;
    #1 chk("quit_ld_ready", ld_ready, 0);
    @(negedge clk); quit = 1'b0; ld_valid = 1'b0;
    chk("quit_load_stage", {stage, busy}, 2'b00);
    chk("partial_board", board, m_pack());

    // Reload restarts at cell 0 and overwrites everything
    pulse_start();
    load_cells(81, 2, -1);
    @(negedge clk); ld_valid = 1'b0;
    chk("reload_board", board, m_pack());
    chk("reload_blank", board_blank, m_blank);
    chk("reload_state", {stage, busy}, 2'b10);
    usr_write(0, 0, 2);
    usr_write(0, 1, 2);
    usr_idle();
    chk("reload_w_board", board, m_pack());

    // Reset in the middle of a clear
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_clear_busy", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_board", board, m_pack());
    chk("arst_blank", board_blank, m_blank);
    chk("arst_stage", stage, 0);
    chk("arst_readies", {ld_ready, usr_ready}, 2'b00);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
